dual_clock_reg_bank: RTL and testbench

DUAL_CLOCK_REG_BANK -- requirements
Module: dual_clock_reg_bank

---
 rtl/dual_clock_reg_bank_pkg.sv | 17 +
 rtl/dcrb_strobe_sync.sv | 43 ++++
 rtl/dual_clock_reg_bank.sv | 87 ++++++++
 tb/tb_dual_clock_reg_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dual_clock_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// dual_clock_reg_bank_pkg
// Shared constants and types for the dual-port register bank.
//   DEFAULT_DEPTH / DEFAULT_WIDTH / DEFAULT_AW : default bank geometry
//   addr_t / data_t                            : address and data word types
//                                                at the default geometry
// -----------------------------------------------------------------------------
package dual_clock_reg_bank_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_AW-1:0]    addr_t;
    typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : dual_clock_reg_bank_pkg

// File: rtl/dcrb_strobe_sync.sv
// -----------------------------------------------------------------------------
// dcrb_strobe_sync
// Brings an asynchronous level (the port-B refresh strobe) into the clk
// domain through a two-flop synchroniser, then flags every level change of
// the synchronised value with a one-cycle pulse.
// Ports:
//   clk         in   sampling clock, rising edge
//   rst_n       in   asynchronous active-low reset, clears all three flops
//   level_async in   asynchronous level to be watched
//   pulse       out  high for one clk cycle after each synchronised change
// -----------------------------------------------------------------------------
module dcrb_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level_async,
    output logic pulse
);

    logic sync_meta;   // first stage, may go metastable
    logic sync_level;  // second stage, safe to use
    logic prev_level;  // previous synchronised level for edge detection

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
            prev_level <= 1'b0;
        end else begin
            sync_meta  <= level_async;
            sync_level <= sync_meta;
            prev_level <= sync_level;
        end
    end

    // Both operands are flops in the clk domain, so the XOR is glitch-free
    // at the consumer. Keeping it combinational holds the overall latency
    // from a strobe transition to a refreshed output at three edges.
    assign pulse = sync_level ^ prev_level;

endmodule : dcrb_strobe_sync

// File: rtl/dual_clock_reg_bank.sv
// -----------------------------------------------------------------------------
// dual_clock_reg_bank
// DEPTH x WIDTH register bank with a write/read port A and a read-only port B.
// All state lives in the CLKA domain; CLKB is only an asynchronous refresh
// strobe whose every level change (after synchronisation) reloads data_outB.
//
// Build option: define DCRB_WR_BYPASS_EN to forward data_inA onto data_outA
// when weA=1 (write-through). Without it a same-address read/write returns
// the old value, the new one appearing a cycle later. Port B never forwards.
//
// Ports:
//   CLKA      in   sole clock, rising edge
//   RSTN      in   asynchronous active-low reset
//   CLKB      in   asynchronous port-B refresh strobe (data, not a clock)
//   addrA     in   port-A write/read address
//   addrB     in   port-B read address, held stable around strobe changes
//   data_inA  in   write data
//   weA       in   write enable, active high
//   data_outA out  registered port-A read data, one-cycle latency
//   data_outB out  registered port-B read data, refreshed on strobe changes
// -----------------------------------------------------------------------------
module dual_clock_reg_bank
    import dual_clock_reg_bank_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLKA,
    input  logic             RSTN,
    input  logic             CLKB,
    input  logic [AW-1:0]    addrA,
    input  logic [AW-1:0]    addrB,
    input  logic [WIDTH-1:0] data_inA,
    input  logic             weA,
    output logic [WIDTH-1:0] data_outA,
    output logic [WIDTH-1:0] data_outB
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             refresh_b;

    dcrb_strobe_sync u_strobe_sync (
        .clk         (CLKA),
        .rst_n       (RSTN),
        .level_async (CLKB),
        .pulse       (refresh_b)
    );

    // NOTE: the storage is cleared by the asynchronous reset on purpose,
    // so the bank reads zero after any reset; this keeps it in flops
    // rather than a RAM macro, which is fine at this size.
    always_ff @(posedge CLKA or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (weA) begin
            mem[addrA] <= data_inA;
        end
    end

    // Port A: unconditional registered read every cycle.
    always_ff @(posedge CLKA or negedge RSTN) begin
        if (!RSTN) begin
            data_outA <= '0;
        end else begin
`ifdef DCRB_WR_BYPASS_EN
            data_outA <= weA ? data_inA : mem[addrA];
`else
            data_outA <= mem[addrA];
`endif
        end
    end

    // Port B: reload only on a synchronised strobe change, otherwise hold.
    // mem is read before this edge's write lands, so a colliding port-A
    // write is seen by port B only on the next refresh.
    always_ff @(posedge CLKA or negedge RSTN) begin
        if (!RSTN) begin
            data_outB <= '0;
        end else if (refresh_b) begin
            data_outB <= mem[addrB];
        end
    end

endmodule : dual_clock_reg_bank

// File: tb/tb_dual_clock_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_dual_clock_reg_bank
// Self-checking bench for dual_clock_reg_bank against an array-based model
// of the bank. Inputs change on the falling edge of CLKA, outputs are
// compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_dual_clock_reg_bank;
    import dual_clock_reg_bank_pkg::*;

`ifdef DCRB_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic  CLKA = 1'b0;
    logic  RSTN;
    logic  CLKB;
    addr_t addrA;
    addr_t addrB;
    data_t data_inA;
    logic  weA;
    data_t data_outA;
    data_t data_outB;

    dual_clock_reg_bank dut (
        .CLKA      (CLKA),
        .RSTN      (RSTN),
        .CLKB      (CLKB),
        .addrA     (addrA),
        .addrB     (addrB),
        .data_inA  (data_inA),
        .weA       (weA),
        .data_outA (data_outA),
        .data_outB (data_outB)
    );

    always #5 CLKA = ~CLKA;

    // Reference model: contents of the bank plus the value port B should show.
    data_t model_mem [16];
    data_t exp_b;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input data_t got, input data_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        exp_b = '0;
    endtask

    // One CLKA cycle with the inputs already driven: predict port A from the
    // model, apply the write to the model, then compare after the edge.
    task automatic cycle(input string tag);
        data_t exp_a;
        exp_a = (BYPASS && weA) ? data_inA : model_mem[addrA];
        if (weA) model_mem[addrA] = data_inA;
        @(posedge CLKA);
        @(negedge CLKA);
        check(tag, data_outA, exp_a);
    endtask

    // Toggle the strobe and give port B its three-edge window, then check it.
    task automatic refresh_b(input string tag);
        CLKB = ~CLKB;
        cycle({tag, "_a0"});
        weA = 1'b0;
        cycle({tag, "_a1"});
        cycle({tag, "_a2"});
        exp_b = model_mem[addrB];
        check({tag, "_b"}, data_outB, exp_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RSTN     = 1'b0;
        CLKB     = 1'b0;
        addrA    = '0;
        addrB    = '0;
        data_inA = '0;
        weA      = 1'b0;
        model_reset();

        // Reset state.
        #12;
        check("rst_a", data_outA, 8'h00);
        check("rst_b", data_outB, 8'h00);
        @(negedge CLKA);
        RSTN = 1'b1;

        // After reset every address reads zero on both ports.
        for (int i = 0; i < 16; i++) begin
            addrA = addr_t'(i);
            addrB = addr_t'(i);
            refresh_b("zero");
        end

        // Fill reg[i] = 0x10 + i.
        for (int i = 0; i < 16; i++) begin
            addrA    = addr_t'(i);
            data_inA = data_t'(8'h10 + i);
            weA      = 1'b1;
            cycle("fill");
        end
        weA = 1'b0;

        // Sweep both ports over the filled bank.
        for (int i = 0; i < 16; i++) begin
            addrA = addr_t'(i);
            addrB = addr_t'(i);
            CLKB  = ~CLKB;
            cycle("sweep_a");
            check("sweep_a_val", data_outA, data_t'(8'h10 + i));
            cycle("sweep_a1");
            cycle("sweep_a2");
            exp_b = model_mem[i];
            check("sweep_b_val", data_outB, data_t'(8'h10 + i));
        end

        // Write AA to address 5, then read it back on both ports.
        addrA    = 4'd5;
        addrB    = 4'd5;
        data_inA = 8'hAA;
        weA      = 1'b1;
        cycle("a5_wr");
        weA = 1'b0;
        cycle("a5_rd");
        check("a5_follow", data_outA, 8'hAA);
        refresh_b("a5");
        check("a5_b_val", data_outB, 8'hAA);

        // Same-cycle read/write at address 3 (old 13, new 5C).
        addrA    = 4'd3;
        data_inA = 8'h5C;
        weA      = 1'b1;
        cycle("rw3_wr");
        check("rw3_first", data_outA, BYPASS ? 8'h5C : 8'h13);
        weA = 1'b0;
        cycle("rw3_rd");
        check("rw3_second", data_outA, 8'h5C);

        // Strobe held constant: port B must not follow addrB.
        for (int i = 0; i < 6; i++) begin
            addrB = addr_t'($urandom_range(0, 15));
            cycle("hold_a");
            check("hold_b", data_outB, exp_b);
        end

        // Randomised traffic. Each burst optionally toggles the strobe; port-A
        // writes avoid addrB during the burst so port B's target is stable.
        for (int burst = 0; burst < 60; burst++) begin
            bit do_toggle;
            do_toggle = 1'($urandom_range(0, 1));
            if (do_toggle) addrB = addr_t'($urandom_range(0, 15));
            if (do_toggle) CLKB = ~CLKB;
            for (int c = 0; c < 3; c++) begin
                addrA    = addr_t'($urandom_range(0, 15));
                data_inA = data_t'($urandom_range(0, 255));
                weA      = 1'($urandom_range(0, 1));
                if (addrA == addrB) weA = 1'b0;
                cycle("rand_a");
            end
            if (do_toggle) exp_b = model_mem[addrB];
            check("rand_b", data_outB, exp_b);
        end

        // Settle the strobe low so reset release leaves nothing pending.
        weA = 1'b0;
        if (CLKB) refresh_b("pre_rst");

        // Reset pulsed between edges during a write of FF to address 9.
        addrA    = 4'd9;
        addrB    = 4'd9;
        data_inA = 8'hFF;
        weA      = 1'b1;
        #2 RSTN = 1'b0;
        #1;
        check("midrst_a", data_outA, 8'h00);
        check("midrst_b", data_outB, 8'h00);
        weA = 1'b0;
        model_reset();
        #1 RSTN = 1'b1;
        cycle("post_rst_a");
        check("post_rst_b_idle", data_outB, 8'h00);
        cycle("post_rst_a1");
        check("post_rst_b_idle1", data_outB, 8'h00);
        refresh_b("post_rst");
        check("reg9_cleared", data_outB, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dual_clock_reg_bank
